// File: rtl/neo_wb_arbiter.sv
// neo_wb_arbiter: round-robin arbiter over NCH memory request channels,
// issuing each grant as one Wishbone B4 classic cycle with lane steering.
module neo_wb_arbiter #(
   parameter int NCH     = 2,
   parameter int AW      = 25,
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [NCH-1:0]    req_valid,
   input  logic [NCH-1:0]    req_we,
   input  logic [NCH*AW-1:0] req_addr,
   input  logic [NCH*DW-1:0] req_wdata,
   output logic [NCH-1:0]    req_ready,
   output logic [NCH-1:0]    rsp_valid,
   output logic              rsp_err,
   output logic [DW-1:0]     rsp_rdata,
   output logic [31:0]       wb_adr_o,
   output logic [31:0]       wb_dat_o,
   input  logic [31:0]       wb_dat_i,
   output logic [3:0]        wb_sel_o,
   output logic              wb_we_o,
   output logic              wb_stb_o,
   output logic              wb_cyc_o,
   input  logic              wb_ack_i,
   input  logic              wb_err_i,
   output logic [2:0]        grant_o,
   output logic [7:0]        timeout_cnt
);

   localparam int L  = 32 / DW;
   localparam int NB = DW / 8;
   localparam int B  = $clog2(NB);
   localparam logic [3:0] SMASK = 4'((1 << NB) - 1);
   localparam logic [7:0] TLAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
   localparam logic [2:0] LAST0 = 3'(NCH - 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t        state, state_n;
   logic [2:0]    last, grant, pick;
   logic          found;
   logic [7:0]    vld8;
   logic [AW-1:0] a_sel;
   logic [DW-1:0] d_sel;
   logic          w_sel;
   logic [1:0]    lane_n, lane_q;
   logic [31:0]   badr;
   logic [DW-1:0] rd_lane;
   logic [7:0]    tcnt, tocnt;
   logic          tmo;

   // rotating priority: first valid channel after the last one granted
   always_comb begin
      vld8  = 8'(req_valid);
      found = 1'b0;
      pick  = '0;
      for (int i = 1; i <= NCH; i++) begin
         if (!found && vld8[3'((int'(last) + i) % NCH)]) begin
            found = 1'b1;
            pick  = 3'((int'(last) + i) % NCH);
         end
      end
   end

   // route the winning channel's request fields
   always_comb begin
      a_sel = '0;
      d_sel = '0;
      w_sel = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (pick == 3'(i)) begin
            a_sel = req_addr[i*AW +: AW];
            d_sel = req_wdata[i*DW +: DW];
            w_sel = req_we[i];
         end
      end
   end

   assign badr   = 32'(a_sel) << B;
   assign lane_n = 2'(a_sel & AW'(L - 1));

   // extract the addressed lane from the returned 32-bit word
   always_comb begin
      rd_lane = '0;
      for (int j = 0; j < L; j++) begin
         if (lane_q == 2'(j)) rd_lane = wb_dat_i[j*DW +: DW];
      end
   end

   // state register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   // next state and handshake/bus strobes
   always_comb begin
      state_n   = state;
      tmo       = 1'b0;
      req_ready = '0;
      rsp_valid = '0;
      wb_cyc_o  = 1'b0;
      wb_stb_o  = 1'b0;
      unique case (state)
         IDLE: begin
            if (found && reset_n) begin
               req_ready = NCH'(1) << pick;
               state_n   = BUS;
            end
         end
         BUS: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            if (wb_ack_i || wb_err_i) begin
               state_n = RESP;
            end else if (TIMEOUT != 0 && tcnt == TLAST) begin
               state_n = RESP;
               tmo     = 1'b1;
            end
         end
         RESP: begin
            rsp_valid = NCH'(1) << grant;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // request latch, bus timer and response capture
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         last      <= LAST0;
         grant     <= '0;
         wb_adr_o  <= '0;
         wb_dat_o  <= '0;
         wb_sel_o  <= '0;
         wb_we_o   <= 1'b0;
         lane_q    <= '0;
         tcnt      <= '0;
         tocnt     <= '0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  last     <= pick;
                  grant    <= pick;
                  wb_adr_o <= badr & 32'hFFFF_FFFC;
                  wb_dat_o <= {L{d_sel}};
                  wb_sel_o <= SMASK << (lane_n * NB);
                  wb_we_o  <= w_sel;
                  lane_q   <= lane_n;
                  tcnt     <= '0;
               end
            end
            BUS: begin
               tcnt <= tcnt + 8'd1;
               if (wb_ack_i || wb_err_i) begin
                  rsp_err   <= wb_err_i;
                  rsp_rdata <= (wb_err_i || wb_we_o) ? '0 : rd_lane;
               end else if (tmo) begin
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  if (tocnt != 8'hFF) tocnt <= tocnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign grant_o     = grant;
   assign timeout_cnt = tocnt;

endmodule

// File: doc/neo_wb_arbiter.md
# neo_wb_arbiter

Parametrised multi-channel memory-request arbiter and Wishbone B4 classic master for the NeoGeo core. It accepts NCH independent SDRAM-style request channels (P-ROM, C-ROM, S-ROM, M-ROM, …) and grants them round-robin. Each granted request becomes one Wishbone cycle with byte-lane steering for narrow data. Read data, a response strobe and an error/timeout flag are returned to the originating channel.

## Interface
- NCH, 2: number of request channels, 1..8.
- AW, 25: request word-address width per channel.
- DW, 16: request data width; 8, 16 or 32 only.
- TIMEOUT, 255: max BUS cycles waiting for ack/err; 0 disables the timeout (width 8 bits, max 255).
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NCH  per-channel request valid; held with its address/data until req_ready.
- req_we  in  NCH  1 = write, 0 = read.
- req_addr  in  NCH*AW  channel i at [i*AW +: AW]; word address in DW units.
- req_wdata  in  NCH*DW  channel i at [i*DW +: DW].
- req_ready  out  NCH  one-hot accept strobe.
- rsp_valid  out  NCH  one-hot one-cycle completion strobe.
- rsp_err  out  1  qualifies rsp_valid: 1 = wb_err_i or timeout.
- rsp_rdata  out  DW  read data, valid with rsp_valid.
- wb_adr_o  out  32  byte address, 4-byte aligned.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_sel_o  out  4  byte enables.
- wb_we_o, wb_stb_o, wb_cyc_o  out  1  Wishbone controls.
- wb_ack_i, wb_err_i  in  1  Wishbone terminations.
- grant_o  out  3  index of the channel owning the current/last transfer.
- timeout_cnt  out  8  saturating count of timeouts since reset.

## Operation
- States: IDLE, BUS, RESP.
- IDLE, arbitration:
  - Search begins at (last+1) mod NCH and takes the first channel with req_valid.
  - req_ready for that channel is asserted combinationally in the same cycle.
  - On that edge the block latches channel index, we, address and wdata, sets last = index, and moves to BUS.
  - If no req_valid is asserted, the block stays in IDLE.
- last resets to NCH-1, so channel 0 wins first.
- Lane steering, with L = 32/DW and B = log2(DW/8):
  - Byte address = req_addr << B.
  - wb_adr_o = byte address with bits[1:0] forced to 0, zero-extended to 32 bits.
  - Lane = req_addr[log2(L)-1:0]; lane is 0 when L = 1.
  - wb_sel_o = ((1<<(DW/8))-1) << (lane*DW/8).
  - wb_dat_o = wdata replicated L times.
- BUS:
  - wb_cyc_o = wb_stb_o = 1; wb_we_o = latched we.
  - The timeout counter increments each BUS cycle.
  - On wb_ack_i: capture wb_dat_i lane into rsp_rdata (writes capture 0); rsp_err = 0; go to RESP.
  - On wb_err_i, or when wb_ack_i and wb_err_i are both high: rsp_err = 1, rsp_rdata = 0, go to RESP.
  - Timeout, when TIMEOUT ≠ 0 and the counter reaches TIMEOUT with no termination:
    - Drop cyc/stb.
    - rsp_err = 1, rsp_rdata = 0.
    - timeout_cnt increments, saturating at 255.
    - Go to RESP.
  - If a termination arrives in the same cycle the counter reaches TIMEOUT, the termination wins.
- RESP:
  - rsp_valid[grant] = 1 for exactly one cycle; cyc/stb low.
  - Next state is IDLE; arbitration resumes the following cycle, so a channel never receives ready in its own RESP cycle.
- wb_ack_i or wb_err_i asserted outside BUS is ignored.
- req_valid dropping before ready: no effect. Dropping after acceptance: the transfer completes normally.
- NCH = 1 degenerates to a single-channel pass-through with identical timing.

## Timing
- Reset (async assert, sync-safe deassert):
  - State IDLE, last = NCH-1, counters 0.
  - All outputs 0, except req_ready, which follows the arbitration rule once reset_n = 1.
- Reset mid-BUS drops cyc/stb immediately (asynchronously); no rsp_valid is issued.
- Cycle-level latency, with accept at cycle 0:
  - stb/cyc first high at cycle 1.
  - Ack sampled at cycle k ≥ 1.
  - rsp_valid at cycle k+1.
  - Next accept possible at k+2.
- Zero-wait-state slave (ack at cycle 1): 3 cycles per transfer.
- wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o are registered and stable for the whole BUS state.
- rsp_rdata and rsp_err hold their value until the next RESP.

## Test plan
- Single read, NCH=2, DW=16: ch0 addr 0x000003, slave acks at cycle 1 with 0xBEEF1234 -> wb_adr_o = 0x4, wb_sel_o = 0xC, rsp_valid[0] at cycle 2, rsp_rdata = 0xBEEF, rsp_err = 0.
- Write lane: ch1 write addr 0x000010, data 0xA5A5 -> wb_adr_o = 0x20, wb_sel_o = 0x3, wb_dat_o = 0xA5A5A5A5, wb_we_o = 1, rsp_valid[1].
- Round-robin: ch0 and ch1 held valid continuously for 6 transfers -> grant sequence 0,1,0,1,0,1; no back-to-back grant of the same channel while the other is waiting.
- Timeout: TIMEOUT = 8, slave never acks -> cyc drops after 8 BUS cycles, rsp_err = 1, rsp_rdata = 0, timeout_cnt = 1. Ack arriving exactly at cycle 8 -> normal completion, timeout_cnt unchanged.
- Error and stray terminations: wb_err_i at cycle 2 -> rsp_err = 1. ack+err asserted together -> rsp_err = 1. Ack pulsed in IDLE -> no state change, no rsp_valid.
- Reset mid-transfer: reset_n low during BUS -> cyc/stb low within the same cycle, no rsp_valid. After release, ch0 is granted first.
